bin2bcd8_060: RTL and testbench

- Sequential binary-to-BCD converter feeding the 8-digit seven-segment scanner.
- Takes one unsigned binary value and produces the eight 4-bit BCD digits that the scanner consumes as its num1..num8 inputs.
- Uses the shift-and-add-3 (double-dabble) method, one bit per clock, with a start/busy/done handshake.
- Result registers hold the last value during a conversion, so the display never shows a partial result.

---
 rtl/bin2bcd8_060_pkg.sv | 15 +
 rtl/bin2bcd8_060_add3.sv | 15 +
 rtl/bin2bcd8_060.sv | 144 ++++++++++++++
 tb/tb_bin2bcd8_060.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd8_060_pkg.sv
// Shared definitions for the 8-digit binary-to-BCD converter:
// FSM state encoding, saturation limit, blank digit code and digit count.
package bin2bcd_pkg_060;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int         MAX_VAL_DEF    = 99_999_999;
  localparam logic [3:0] BLANK_CODE_DEF = 4'hF;
  localparam int         NUM_DIGITS     = 8;

endpackage

// File: rtl/bin2bcd8_060_add3.sv
// Double-dabble nibble corrector: adds 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_add3_060 (
  input  logic [3:0] bcd,
  output logic [3:0] corr
);

  always_comb begin
    corr = bcd;
    if (bcd >= 4'd5) begin
      corr = bcd + 4'd3;
    end
  end

endmodule

// File: rtl/bin2bcd8_060.sv
// Sequential shift-and-add-3 binary-to-BCD converter for the 8-digit scanner.
// Optional macro BIN2BCD_LEADING_BLANK_EN replaces leading zero digits with BLANK_CODE.
module bin2bcd8_060
  import bin2bcd_pkg_060::*;
#(
  parameter int BIN_W   = 27,
  parameter int MAX_VAL = MAX_VAL_DEF
`ifdef BIN2BCD_LEADING_BLANK_EN
  , parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF
`endif
) (
  input  logic             I_clk_060,
  input  logic             I_rst_n_060,
  input  logic             I_start_060,
  input  logic [BIN_W-1:0] I_bin_060,
  output logic             O_busy_060,
  output logic             O_done_060,
  output logic             O_ovf_060,
  output logic [3:0]       O_num1_060,
  output logic [3:0]       O_num2_060,
  output logic [3:0]       O_num3_060,
  output logic [3:0]       O_num4_060,
  output logic [3:0]       O_num5_060,
  output logic [3:0]       O_num6_060,
  output logic [3:0]       O_num7_060,
  output logic [3:0]       O_num8_060
);

  localparam int               CNT_W     = $clog2(BIN_W + 1);
  localparam int               ACC_W     = 4 * NUM_DIGITS;
  localparam logic [BIN_W-1:0] MAX_VAL_W = BIN_W'(MAX_VAL);
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(BIN_W - 1);

  state_t                   state_q;
  state_t                   state_d;
  logic [BIN_W-1:0]         bin_q;
  logic [ACC_W-1:0]         acc_q;
  logic [ACC_W-1:0]         acc_corr;
  logic [ACC_W+BIN_W-1:0]   shift_vec;
  logic [CNT_W-1:0]         cnt_q;
  logic                     ovf_pend_q;
  logic                     busy_q;
  logic                     done_q;
  logic                     ovf_q;
  logic [ACC_W-1:0]         num_q;
  logic [ACC_W-1:0]         done_digits;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3_060 u_add3 (
      .bcd  (acc_q[4*g +: 4]),
      .corr (acc_corr[4*g +: 4])
    );
  end

  // Corrected accumulator and remaining binary bits move left together.
  assign shift_vec = {acc_corr, bin_q} << 1;

  always_ff @(posedge I_clk_060 or negedge I_rst_n_060) begin
    if (!I_rst_n_060) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (I_start_060) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST_CNT) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Saturated inputs show all nines regardless of the shifted result.
  always_comb begin
    done_digits = ovf_pend_q ? {NUM_DIGITS{4'h9}} : acc_q;
`ifdef BIN2BCD_LEADING_BLANK_EN
    if (!ovf_pend_q) begin
      logic lead;
      lead = 1'b1;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        if (lead && (acc_q[4*i +: 4] == 4'h0)) begin
          done_digits[4*i +: 4] = BLANK_CODE;
        end else begin
          lead = 1'b0;
        end
      end
    end
`endif
  end

  always_ff @(posedge I_clk_060 or negedge I_rst_n_060) begin
    if (!I_rst_n_060) begin
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_pend_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
      num_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (I_start_060) begin
            bin_q      <= I_bin_060;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= (I_bin_060 > MAX_VAL_W);
            busy_q     <= 1'b1;
          end
        end
        SHIFT: begin
          acc_q <= shift_vec[ACC_W+BIN_W-1 -: ACC_W];
          bin_q <= shift_vec[BIN_W-1:0];
          cnt_q <= cnt_q + 1'b1;
        end
        DONE: begin
          num_q  <= done_digits;
          ovf_q  <= ovf_pend_q;
          done_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign O_busy_060 = busy_q;
  assign O_done_060 = done_q;
  assign O_ovf_060  = ovf_q;
  assign O_num1_060 = num_q[3:0];
  assign O_num2_060 = num_q[7:4];
  assign O_num3_060 = num_q[11:8];
  assign O_num4_060 = num_q[15:12];
  assign O_num5_060 = num_q[19:16];
  assign O_num6_060 = num_q[23:20];
  assign O_num7_060 = num_q[27:24];
  assign O_num8_060 = num_q[31:28];

endmodule

// File: tb/tb_bin2bcd8_060.sv
// Scoreboard bench for bin2bcd8_060: directed vectors with hand-computed digits,
// checked by a done-triggered monitor (expectations follow BIN2BCD_LEADING_BLANK_EN).
module tb_bin2bcd8_060;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [26:0] bin = '0;
  logic        busy, done, ovf;
  logic [3:0]  n1, n2, n3, n4, n5, n6, n7, n8;
  logic [31:0] nums;

  typedef struct {
    logic [31:0] num;
    logic        ovf;
    int          start_edge;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   busy_run = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  bin2bcd8_060 dut (
    .I_clk_060   (clk),
    .I_rst_n_060 (rst_n),
    .I_start_060 (start),
    .I_bin_060   (bin),
    .O_busy_060  (busy),
    .O_done_060  (done),
    .O_ovf_060   (ovf),
    .O_num1_060  (n1),
    .O_num2_060  (n2),
    .O_num3_060  (n3),
    .O_num4_060  (n4),
    .O_num5_060  (n5),
    .O_num6_060  (n6),
    .O_num7_060  (n7),
    .O_num8_060  (n8)
  );

  assign nums = {n8, n7, n6, n5, n4, n3, n2, n1};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] pick(input logic [31:0] plain, input logic [31:0] blanked);
`ifdef BIN2BCD_LEADING_BLANK_EN
    return blanked;
`else
    return plain;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [26:0] value, input logic [31:0] exp_num, input logic exp_ovf);
    exp_t e;
    @(negedge clk);
    bin   = value;
    start = 1'b1;
    e.num = exp_num;
    e.ovf = exp_ovf;
    e.start_edge = cyc + 1;
    exp_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitDone(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (done_cnt < target) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_timeout: got %0d done pulses expected %0d", done_cnt, target);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        exp_t e;
        done_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got digits %h expected no done", nums);
        end else begin
          e = exp_q.pop_front();
          checkOutput("digits", nums, e.num);
          checkOutput("ovf", {31'd0, ovf}, {31'd0, e.ovf});
          checkOutput("latency", 32'(cyc - e.start_edge), 32'd28);
          checkOutput("busy_len", 32'(busy_run), 32'd28);
        end
        busy_run = 0;
      end
    end
  end

  initial begin
    #100us;
    $display("[TB] FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rst_digits", nums, 32'h0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_done", {31'd0, done}, 32'd0);
    checkOutput("rst_ovf", {31'd0, ovf}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(27'd0, pick(32'h00000000, 32'hFFFFFFF0), 1'b0);
    waitDone(1);

    applyStimulus(27'd12_345_678, 32'h12345678, 1'b0);
    waitDone(2);
    @(negedge clk);
    bin = 27'd0;
    repeat (10) @(negedge clk);
    checkOutput("hold_digits", nums, 32'h12345678);
    checkOutput("hold_busy", {31'd0, busy}, 32'd0);

    applyStimulus(27'd99_999_999, 32'h99999999, 1'b0);
    waitDone(3);
    applyStimulus(27'd100_000_000, 32'h99999999, 1'b1);
    waitDone(4);
    applyStimulus(27'h7FF_FFFF, 32'h99999999, 1'b1);
    waitDone(5);
    repeat (3) @(negedge clk);
    checkOutput("ovf_hold", {31'd0, ovf}, 32'd1);

    applyStimulus(27'd305, pick(32'h00000305, 32'hFFFFF305), 1'b0);
    waitDone(6);

    // Second start at edge 10 of a conversion must be dropped.
    applyStimulus(27'd12_345_678, 32'h12345678, 1'b0);
    repeat (9) @(negedge clk);
    bin   = 27'd55;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDone(7);
    repeat (40) @(negedge clk);
    checkOutput("single_done", 32'(done_cnt), 32'd7);

    // Reset mid-conversion aborts without a done pulse.
    applyStimulus(27'd87_654_321, 32'h87654321, 1'b0);
    repeat (14) @(negedge clk);
    checkOutput("busy_mid", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_digits", nums, 32'h0);
    checkOutput("abort_busy", {31'd0, busy}, 32'd0);
    checkOutput("abort_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    repeat (40) @(negedge clk);
    checkOutput("no_done_abort", 32'(done_cnt), 32'd7);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(27'd42, pick(32'h00000042, 32'hFFFFFF42), 1'b0);
    waitDone(8);
    repeat (5) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
